// File: rtl/pc_gen.sv
// pc_gen: instruction fetch address generator.
// Each edge picks the next fetch PC from one of these sources, highest first:
// flush, stall (hold), taken branch, pending branch target, sequential.
// A branch that arrives during a stall is held until the stall releases.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    stall vector; only bit 0 (freeze fetch) is used
//   flush_i, new_pc_i        flush request and its target
//   branch_flag_i            taken-branch indication
//   branch_target_address_i  branch target
//   pc, ce                   registered fetch address and instruction-memory enable
//   pend_o                   registered: a branch target is waiting for the stall to end
//   misalign_o               registered pulse: the last loaded target had nonzero low bits
module pc_gen #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       STALL_W    = 6,
  parameter int unsigned       INST_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  new_pc_i,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               pend_o,
  output logic               misalign_o
);

  // Byte-offset bits within one instruction, and the sequential step.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INST_BYTES);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q, ce_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              mis_q, mis_d;
  logic              load_c;
  logic [ADDR_W-1:0] load_addr_c;
  logic              unused_stall;

  // Only stall[0] matters; the reduction keeps the upper bits formally consumed.
  assign unused_stall = ^stall;

  // Next-state selection.
  always_comb begin
    pc_d        = pc_q;
    ce_d        = 1'b1;
    pend_d      = pend_q;
    tgt_d       = tgt_q;
    mis_d       = 1'b0;
    load_c      = 1'b0;
    load_addr_c = '0;

    if (!ce_q) begin
      pc_d   = RESET_VEC;
      pend_d = 1'b0;
      tgt_d  = '0;
    end else if (flush_i) begin
      load_c      = 1'b1;
      load_addr_c = new_pc_i;
      pend_d      = 1'b0;
      tgt_d       = '0;
    end else if (stall[0]) begin
      // Latest branch seen during the stall wins.
      if (branch_flag_i) begin
        pend_d = 1'b1;
        tgt_d  = branch_target_address_i;
      end
    end else if (branch_flag_i) begin
      load_c      = 1'b1;
      load_addr_c = branch_target_address_i;
      pend_d      = 1'b0;
      tgt_d       = '0;
    end else if (pend_q) begin
      load_c      = 1'b1;
      load_addr_c = tgt_q;
      pend_d      = 1'b0;
      tgt_d       = '0;
    end else begin
      pc_d = pc_q + STEP;
    end

    // Loaded targets are aligned; report any dropped offset bits.
    if (load_c) begin
      pc_d  = load_addr_c & ~LOW_MASK;
      mis_d = |(load_addr_c & LOW_MASK);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_VEC;
      ce_q   <= 1'b0;
      pend_q <= 1'b0;
      tgt_q  <= '0;
      mis_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ce_q   <= ce_d;
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
      mis_q  <= mis_d;
    end
  end

  assign pc         = pc_q;
  assign ce         = ce_q;
  assign pend_o     = pend_q;
  assign misalign_o = mis_q;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32: PC and target address width in bits.
REQ-002 Parameter STALL_W, default 6: stall vector width; only bit 0 is consumed.
REQ-003 Parameter INST_BYTES, default 4: sequential increment in bytes; a power of two, at least 1.
REQ-004 Parameter RESET_VEC, default 0: PC value held in reset and while ce is low.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 stall  in  STALL_W  pipeline stall vector from control; bit 0 = 1 freezes fetch.
REQ-008 flush_i  in  1  exception/flush request from control.
REQ-009 new_pc_i  in  ADDR_W  flush target address.
REQ-010 branch_flag_i  in  1  taken-branch indication from decode.
REQ-011 branch_target_address_i  in  ADDR_W  branch target address.
REQ-012 pc  out  ADDR_W  registered fetch address.
REQ-013 ce  out  1  registered instruction-memory chip enable.
REQ-014 pend_o  out  1  registered flag: a branch target is captured and awaiting release.
REQ-015 misalign_o  out  1  registered one-cycle pulse: the last loaded target had nonzero low bits.

Function
REQ-016 ce SHALL rise to 1 on the first clock edge with rst low, and stay 1 until rst is asserted again.
REQ-017 While ce is 0, pc SHALL equal RESET_VEC, pend_o SHALL be 0 and the pending target SHALL be cleared.
REQ-018 With ce at 1, the next-PC source SHALL use this fixed priority: flush, then stall, then branch, then pending, then sequential.
REQ-019 Flush: when flush_i is 1, pc SHALL load new_pc_i on the next edge and pend_o SHALL clear, regardless of stall[0] or branch_flag_i.
REQ-020 Stall: when stall[0] is 1 and flush_i is 0, pc SHALL hold its value.
REQ-021 Stall with branch: a branch_flag_i seen during a stall SHALL capture branch_target_address_i into the pending register and set pend_o.
REQ-022 A newer branch during the same stall SHALL overwrite the pending target.
REQ-023 Branch: when stall[0] is 0 and branch_flag_i is 1, pc SHALL load branch_target_address_i and pend_o SHALL clear; a live branch wins over a pending target.
REQ-024 Pending release: when stall[0] is 0, branch_flag_i is 0 and pend_o is 1, pc SHALL load the pending target and pend_o SHALL clear in the same edge.
REQ-025 Sequential: otherwise pc SHALL load pc + INST_BYTES, truncated to ADDR_W bits, so the value wraps modulo 2^ADDR_W.
REQ-026 Every loaded target (flush, branch or pending) SHALL have its low log2(INST_BYTES) bits forced to 0 before reaching pc.
REQ-027 misalign_o SHALL pulse for exactly the one cycle after such a load if any masked bit was 1, and SHALL be 0 otherwise.
REQ-028 Latency: every pc change SHALL appear one clock after the causing inputs; there SHALL be no combinational path from any input to any output.
REQ-029 Bits of stall above bit 0 SHALL have no effect.

Reset
REQ-030 With rst high, the next edge SHALL set pc=RESET_VEC, ce=0, pend_o=0, misalign_o=0 and clear the pending target.
REQ-031 rst SHALL take priority over all other inputs, including reset asserted mid-stall with a target pending: the pending target is discarded.

Verification
REQ-032 Release reset with defaults and no stall or branch -> ce=1 after 1 edge; pc then reads 0, 4, 8, 12 on successive edges.
REQ-033 Hold stall[0]=1 for 3 cycles, pulse branch to 0x100 in cycle 2 -> pc frozen, pend_o=1; on release pc=0x100 and pend_o=0 on the same edge.
REQ-034 During a stall, branch to 0x100 then 0x200; on release assert a live branch to 0x300 -> pc=0x300 and pend_o clears.
REQ-035 flush_i=1 with new_pc_i=0x80, stall[0]=1 and branch_flag_i=1 all asserted -> pc=0x80 next edge; pend_o=0.
REQ-036 Set pc=0xFFFFFFFC, then run with no stall or branch -> next pc=0x00000000; branch to 0x103 -> pc=0x100 and misalign_o=1 for exactly one cycle.
